// File: rtl/gf2m_serial_mult_if.sv
// Operand/product handshake bundle for gf2m_serial_mult.
// master = operand producer / product consumer, slave = the multiplier.
interface gf2m_serial_mult_if #(
  parameter int M = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] p;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/gf2m_serial_mult.sv
// Digit-serial GF(2^M) multiplier: p = a*b mod POLY, DIGIT bits of b per
// cycle, MSB-first. Fixed, data-independent latency of M/DIGIT cycles.
// Optional build macro: GF_MULT_ZEROIZE_EN clears operand, accumulator and
// product registers on the output handshake so no residue remains.
module gf2m_serial_mult #(
  parameter int         M     = 8,
  parameter logic [M:0] POLY  = 9'h11B,
  parameter int         DIGIT = 1
) (
  input logic               clk,
  input logic               rst_n,
  gf2m_serial_mult_if.slave bus
);

  localparam int STEPS = M / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Reject parameter sets the datapath cannot implement.
  if (M < 2 || (M % DIGIT) != 0 || POLY[M] != 1'b1) begin : g_bad_params
    $fatal(1, "gf2m_serial_mult: illegal parameters M=%0d DIGIT=%0d POLY=%0h", M, DIGIT, POLY);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [M-1:0]     a_r;
  logic [M-1:0]     b_r;
  logic [M-1:0]     acc;
  logic [M-1:0]     p_r;
  logic [CNT_W-1:0] cnt;
  logic [M-1:0]     acc_nxt;
  logic [M-1:0]     b_nxt;

  // Multiply by x with reduction: the former combinational xtime stage.
  function automatic logic [M-1:0] xt(input logic [M-1:0] x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY[M-1:0] : '0);
  endfunction

  // One digit of Horner evaluation: DIGIT iterations of acc = x*acc + b_msb*a.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    acc_nxt = acc;
    b_nxt   = b_r;
    for (int i = 0; i < DIGIT; i++) begin
      acc_nxt = xt(acc_nxt) ^ (b_nxt[M-1] ? a_r : '0);
      b_nxt   = {b_nxt[M-2:0], 1'b0};
    end
  end

  // Control FSM and datapath registers; no early exit keeps timing constant.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain registers (no memory array), so all are reset.
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      p_r   <= '0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            acc   <= '0;
            cnt   <= CNT_W'(STEPS - 1);
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          b_r <= b_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            p_r   <= acc_nxt;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
`ifdef GF_MULT_ZEROIZE_EN
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            p_r <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.p         = p_r;

endmodule

// File: tb/tb_gf2m_serial_mult.sv
// Self-checking bench for gf2m_serial_mult: directed vectors, backpressure,
// mid-operation reset, wider digits, a small field, and a randomized run
// checked against an independent LSB-first reference model via a scoreboard.
module tb_gf2m_serial_mult;

  localparam int M     = 8;
  localparam int DIGIT = 1;
  localparam int LAT   = M / DIGIT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gf2m_serial_mult_if #(.M(8)) ifc ();
  gf2m_serial_mult_if #(.M(8)) ifc4 ();
  gf2m_serial_mult_if #(.M(4)) ifcm ();

  gf2m_serial_mult #(.M(8), .POLY(9'h11B), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  gf2m_serial_mult #(.M(8), .POLY(9'h11B), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ifc4.slave));
  gf2m_serial_mult #(.M(4), .POLY(5'h13), .DIGIT(1)) dutm (
    .clk(clk), .rst_n(rst_n), .bus(ifcm.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: LSB-first shift-and-add in GF(2^8) with AES polynomial.
  function automatic logic [7:0] gf_mul8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r = 8'h00;
    logic [7:0] t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) r = r ^ t;
      t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
    end
    return r;
  endfunction

  // Scoreboard / monitor on the main instance, sampled on the falling edge.
  logic [7:0] exp_q[$];
  int cyc = 0;
  int acc_cyc = 0;
  int out_cnt = 0;
  bit ov_prev = 1'b0;
  bit seen_hs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (ifc.out_valid && !ov_prev) check("latency", cyc - acc_cyc, LAT);
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else check("sb_p", ifc.p, exp_q.pop_front());
        out_cnt++;
        seen_hs = 1'b1;
      end
`ifdef GF_MULT_ZEROIZE_EN
      if (!ifc.out_valid && seen_hs) check("p_zero", ifc.p, 0);
`endif
      if (ifc.in_valid && ifc.in_ready) begin
        exp_q.push_back(gf_mul8(ifc.a, ifc.b));
        acc_cyc = cyc + 1;
      end
      ov_prev = ifc.out_valid;
    end
  end

  // One operation on an idle main DUT with out_ready high; checks a known product.
  task automatic run_known(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic [7:0] te);
    int n = 0;
    @(posedge clk); #1;
    ifc.in_valid = 1'b1; ifc.a = ta; ifc.b = tb_v; ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    while (!ifc.out_valid && n < 40) begin @(negedge clk); n++; end
    check({tag, "_valid"}, ifc.out_valid, 1);
    check(tag, ifc.p, te);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat4, latm, guard, target;
    ifc.in_valid = 0; ifc.a = 0; ifc.b = 0; ifc.out_ready = 0;
    ifc4.in_valid = 0; ifc4.a = 0; ifc4.b = 0; ifc4.out_ready = 1;
    ifcm.in_valid = 0; ifcm.a = 0; ifcm.b = 0; ifcm.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", ifc.in_ready, 1);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_p", ifc.p, 0);
    rst_n = 1'b1;

    // Directed vectors in the AES field.
    run_known("p_57x83", 8'h57, 8'h83, 8'hC1);
    run_known("p_57x13", 8'h57, 8'h13, 8'hFE);
    run_known("p_02x80", 8'h02, 8'h80, 8'h1B);
    run_known("p_00xAE", 8'h00, 8'hAE, 8'h00);
    run_known("p_01xAE", 8'h01, 8'hAE, 8'hAE);

    // Backpressure; operand changes and in_valid while busy must be ignored.
    @(posedge clk); #1;
    ifc.in_valid = 1'b1; ifc.a = 8'h57; ifc.b = 8'h83; ifc.out_ready = 1'b0;
    @(posedge clk); #1;
    ifc.a = 8'hFF; ifc.b = 8'hFF;
    guard = 0;
    while (!ifc.out_valid && guard < 40) begin @(negedge clk); guard++; end
    check("bp_valid", ifc.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_p", ifc.p, 8'hC1);
      check("bp_in_ready", ifc.in_ready, 0);
      check("bp_busy", ifc.busy, 1);
      @(negedge clk);
      check("bp_hold", ifc.out_valid, 1);
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_in_ready", ifc.in_ready, 1);
    check("bp_idle_out_valid", ifc.out_valid, 0);

    // Reset in the middle of RUN discards the operation.
    @(posedge clk); #1;
    ifc.in_valid = 1'b1; ifc.a = 8'h57; ifc.b = 8'h83;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    guard = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ifc.out_valid) guard++;
    end
    check("rst_mid_no_valid", guard, 0);
    check("rst_mid_in_ready", ifc.in_ready, 1);
    check("rst_mid_p", ifc.p, 0);
    run_known("p_after_rst", 8'h57, 8'h13, 8'hFE);

    // Wider digit and a 4-bit field, latency counted from the accept edge.
    @(posedge clk); #1;
    ifc4.in_valid = 1'b1; ifc4.a = 8'h57; ifc4.b = 8'h83;
    ifcm.in_valid = 1'b1; ifcm.a = 4'h3; ifcm.b = 4'h7;
    @(posedge clk); #1;
    ifc4.in_valid = 1'b0; ifcm.in_valid = 1'b0;
    lat4 = -1; latm = -1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc4.out_valid && lat4 < 0) begin lat4 = n; check("d4_p", ifc4.p, 8'hC1); end
      if (ifcm.out_valid && latm < 0) begin latm = n; check("m4_p", ifcm.p, 4'h9); end
    end
    check("d4_latency", lat4, 2);
    check("m4_latency", latm, 4);

    // Randomized traffic with random in_valid and out_ready.
    target = out_cnt + 1000;
    guard = 0;
    while (out_cnt < target && guard < 50000) begin
      @(posedge clk); #1;
      ifc.in_valid  = ($urandom_range(0, 1) == 1);
      ifc.a         = 8'($urandom);
      ifc.b         = 8'($urandom);
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin @(posedge clk); guard++; end
    #1;
    check("rand_ops_done", (out_cnt >= target), 1);
    check("rand_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
